// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI slave front end and the memory controller
// that consumes its byte stream.
package spi_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE = 2'd0;
  localparam spi_state_t ST_CMD  = 2'd1;
  localparam spi_state_t ST_DATA = 2'd2;

  // Command bit carried in the MSB of the first byte of every frame
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the byte-level link to the memory controller.
// Handshake: transaction_done is a one-clk strobe qualifying rx_data (no back-pressure);
// spi_load_en is a one-clk strobe qualifying tx_data (always accepted).
interface spi_slave_if_if #(
  parameter int DATA_WIDTH = spi_mem_pkg::DEF_DATA_WIDTH
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  transaction_done;
  logic                  read_write;
  logic                  frame_active;
  logic                  spi_load_en;
  logic [DATA_WIDTH-1:0] tx_data;

  modport slave (
    input  sclk, cs_n, mosi, spi_load_en, tx_data,
    output miso, rx_data, transaction_done, read_write, frame_active
  );

  modport master (
    output sclk, cs_n, mosi, spi_load_en, tx_data,
    input  miso, rx_data, transaction_done, read_write, frame_active
  );
endinterface

// File: rtl/spi_slave_if_sync.sv
// Multi-flop synchroniser for one asynchronous input with rise/fall pulses
// derived from the last two synchronised samples. STAGES must be at least 2.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              q_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      q_d    <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q_d    <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversampled inputs, byte deserialiser, command
// bit capture and MISO serialiser feeding the memory controller FSM.
module spi_slave_if
  import spi_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  spi_slave_if_if.slave bus,
  output logic [1:0]    fsm_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d(bus.sclk),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .reset_n(reset_n), .d(bus.cs_n),
    .q(cs_n_s), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(bus.mosi),
    .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Frame exit is level-based on cs_n_s, so the cs_n rise pulse is redundant
  assign unused_edges = ^{sclk_s, cs_rise, mosi_rise, mosi_fall};

  spi_state_t            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [DATA_WIDTH-1:0] byte_buf_q;
  logic                  byte_done_q;
  logic                  byte_cmd_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  done_q;
  logic                  rw_q;

  logic active;
  logic leaving;
  logic rx_take;
  logic last_bit;
  logic byte_end;

  // Edges are still accepted in the clk where cs_n_s rises: state is not yet IDLE
  assign active   = (state_q != ST_IDLE);
  assign leaving  = active && cs_n_s;
  assign rx_take  = active && sclk_rise;
  assign last_bit = (bit_cnt_q == CNT_W'(DATA_WIDTH-1));
  assign byte_end = rx_take && last_bit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cs_fall)        state_d = ST_CMD;
      ST_CMD:  if (cs_n_s)         state_d = ST_IDLE;
               else if (byte_end)  state_d = ST_DATA;
      ST_DATA: if (cs_n_s)         state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
    end else begin
      state_q <= state_d;
      if (leaving) begin
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
      end else if (rx_take) begin
        bit_cnt_q  <= last_bit ? '0 : bit_cnt_q + 1'b1;
        rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
      end
    end
  end

  // Completed byte is parked one clk so a coincident frame exit cannot lose it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_done_q <= 1'b0;
      byte_cmd_q  <= 1'b0;
      byte_buf_q  <= '0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rw_q        <= RW_READ;
    end else begin
      byte_done_q <= byte_end;
      if (byte_end) begin
        byte_buf_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
        byte_cmd_q <= (state_q == ST_CMD);
      end
      done_q <= byte_done_q;
      if (byte_done_q) begin
        rx_data_q <= byte_buf_q;
        if (byte_cmd_q) rw_q <= byte_buf_q[DATA_WIDTH-1];
      end
    end
  end

  // A load beats a coincident falling edge so the new MSB is never skipped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_q <= '0;
    end else if (bus.spi_load_en) begin
      tx_shift_q <= bus.tx_data;
    end else if (leaving) begin
      tx_shift_q <= '0;
    end else if (active && sclk_fall) begin
      tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign bus.miso             = active & tx_shift_q[DATA_WIDTH-1];
  assign bus.rx_data          = rx_data_q;
  assign bus.transaction_done = done_q;
  assign bus.read_write       = rw_q;
  assign bus.frame_active     = ~cs_n_s;
  assign fsm_state            = state_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: bit-banged SPI master at clk:SCLK = 8:1 with an
// expected-byte queue checked against every transaction_done pulse.
module tb_spi_slave_if;
  import spi_mem_pkg::*;

  localparam int W    = DEF_DATA_WIDTH;
  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] fsm_state;

  spi_slave_if_if #(.DATA_WIDTH(W)) bus ();

  spi_slave_if #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    bus.cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic end_frame();
    wait_clk(HALF);
    bus.cs_n = 1'b1;
    wait_clk(4 * HALF);
  endtask

  // Mode 0: MOSI set while SCLK low, both sides sample on the rising edge
  task automatic spi_xfer(input logic [W-1:0] tx, input int nbits, input bit cs_on_last,
                          output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[W-1-i];
      wait_clk(HALF);
      bus.sclk = 1'b1;
      rx[W-1-i] = bus.miso;
      if (cs_on_last && i == nbits - 1) bus.cs_n = 1'b1;
      if (i == W - 1) exp_q.push_back(tx);
      wait_clk(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  // aligned=1 lands the load in the same clk as the detected falling edge
  task automatic load_tx(input logic [W-1:0] data, input bit aligned);
    wait_clk(aligned ? SYNC : SYNC + 4);
    bus.tx_data     = data;
    bus.spi_load_en = 1'b1;
    wait_clk(1);
    bus.spi_load_en = 1'b0;
    if (aligned) check("miso_after_load", bus.miso, data[W-1]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_miso"},   bus.miso, 0);
    check({tag, "_rx"},     bus.rx_data, 0);
    check({tag, "_done"},   bus.transaction_done, 0);
    check({tag, "_rw"},     bus.read_write, 0);
    check({tag, "_active"}, bus.frame_active, 0);
    check({tag, "_state"},  fsm_state, ST_IDLE);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && bus.transaction_done) begin
      if (exp_q.size() == 0) check("spurious_done", bus.transaction_done, 0);
      else                   check("rx_data", bus.rx_data, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] rnd;

    bus.sclk = 1'b0;  bus.cs_n = 1'b1;  bus.mosi = 1'b0;
    bus.spi_load_en = 1'b0;  bus.tx_data = '0;
    wait_clk(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    wait_clk(3);
    check_outputs_zero("post_reset");

    // Write frame: command 0x85 then data 0x3C
    start_frame();
    check("frame_active", bus.frame_active, 1);
    spi_xfer(8'h85, 8, 1'b0, rx);
    wait_clk(2);
    check("rw_write_cmd", bus.read_write, RW_WRITE);
    check("state_data", fsm_state, ST_DATA);
    spi_xfer(8'h3C, 8, 1'b0, rx);
    end_frame();
    check("rw_hold_after_frame", bus.read_write, RW_WRITE);
    check("state_idle", fsm_state, ST_IDLE);

    // Reset part-way through a byte, then one full byte
    start_frame();
    spi_xfer(8'hA5, 4, 1'b0, rx);
    reset_n = 1'b0;
    wait_clk(1);
    check_outputs_zero("mid_reset");
    bus.cs_n = 1'b1;  bus.sclk = 1'b0;  bus.mosi = 1'b0;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(4);
    start_frame();
    spi_xfer(8'h91, 8, 1'b0, rx);
    end_frame();
    check("rw_after_reset_frame", bus.read_write, RW_WRITE);

    // Aborted frame: five bits of 0xFF, no done
    start_frame();
    spi_xfer(8'hFF, 5, 1'b0, rx);
    end_frame();
    check("abort_state", fsm_state, ST_IDLE);
    check("abort_active", bus.frame_active, 0);
    check("abort_rx_kept", bus.rx_data, 8'h91);
    start_frame();
    spi_xfer(8'h01, 8, 1'b0, rx);
    end_frame();
    check("rw_after_abort", bus.read_write, RW_READ);

    // CS_N rises together with the last rising SCLK edge: byte still completes
    start_frame();
    spi_xfer(8'hC3, 8, 1'b1, rx);
    wait_clk(4 * HALF);
    check("rw_cs_collision", bus.read_write, RW_WRITE);
    check("cs_collision_state", fsm_state, ST_IDLE);

    // Back-to-back frames with random data bytes
    start_frame();
    spi_xfer(8'h40, 8, 1'b0, rx);
    for (int i = 0; i < 3; i++) begin
      rnd = W'($urandom_range(0, 255));
      spi_xfer(rnd, 8, 1'b0, rx);
    end
    end_frame();
    check("rw_b2b_first", bus.read_write, RW_READ);
    start_frame();
    spi_xfer(8'h9E, 8, 1'b0, rx);
    end_frame();
    check("rw_b2b_second", bus.read_write, RW_WRITE);

    // Read frame: load well after the trailing falling edge
    start_frame();
    spi_xfer(8'h05, 8, 1'b0, rx);
    load_tx(8'hA7, 1'b0);
    spi_xfer(8'h00, 8, 1'b0, rx);
    check("miso_read_byte", rx, 8'hA7);
    end_frame();
    check("rw_read", bus.read_write, RW_READ);
    check("miso_idle", bus.miso, 0);

    // Load coincident with a detected falling edge
    start_frame();
    spi_xfer(8'h06, 8, 1'b0, rx);
    load_tx(8'h5A, 1'b1);
    spi_xfer(8'hFF, 8, 1'b0, rx);
    check("miso_collision_byte", rx, 8'h5A);
    end_frame();

    wait_clk(10);
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
